// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the 5-stage pipeline and its stall/flush
// controller.
//   master : the pipeline side. It drives the ID/EX/MEM hazard sources and
//            receives the stall/flush/bubble controls.
//   slave  : the controller side (pipe_hazard_ctrl).
// Hazard sources:
//   id_rs1_addr_i/ren_i, id_rs2_addr_i/ren_i         ID operand use
//   ex_wb_addr_i, ex_wb_en_i, ex_mem_r_en_i          ID/EX register fields
//   ex_redirect_i, ex_mdu_op_i, mdu_done_i           EX events
//   mem_req_i, mem_ready_i                           MEM handshake
// Controls: pc/if_id/id_ex/ex_mem stalls, if_id flush, hazard_flush (ID/EX
//   bubble), ex_mem and mem_wb bubbles.
interface pipe_hazard_if;
    logic [4:0] id_rs1_addr_i;
    logic       id_rs1_ren_i;
    logic [4:0] id_rs2_addr_i;
    logic       id_rs2_ren_i;
    logic [4:0] ex_wb_addr_i;
    logic       ex_wb_en_i;
    logic       ex_mem_r_en_i;
    logic       ex_redirect_i;
    logic       ex_mdu_op_i;
    logic       mdu_done_i;
    logic       mem_req_i;
    logic       mem_ready_i;

    logic       pc_stall_o;
    logic       if_id_stall_o;
    logic       if_id_flush_o;
    logic       hazard_flush_o;
    logic       id_ex_stall_o;
    logic       ex_mem_stall_o;
    logic       ex_mem_bubble_o;
    logic       mem_wb_bubble_o;

    modport master (
        output id_rs1_addr_i, id_rs1_ren_i, id_rs2_addr_i, id_rs2_ren_i,
               ex_wb_addr_i, ex_wb_en_i, ex_mem_r_en_i, ex_redirect_i,
               ex_mdu_op_i, mdu_done_i, mem_req_i, mem_ready_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, hazard_flush_o,
               id_ex_stall_o, ex_mem_stall_o, ex_mem_bubble_o, mem_wb_bubble_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs1_ren_i, id_rs2_addr_i, id_rs2_ren_i,
               ex_wb_addr_i, ex_wb_en_i, ex_mem_r_en_i, ex_redirect_i,
               ex_mdu_op_i, mdu_done_i, mem_req_i, mem_ready_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, hazard_flush_o,
               id_ex_stall_o, ex_mem_stall_o, ex_mem_bubble_o, mem_wb_bubble_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the IF/ID/EX/MEM/WB core.
// Resolves load-use hazards, taken-branch redirects, multi-cycle MDU ops and
// LSU wait states. It also keeps a saturating stall-cycle counter and a
// sticky wait-state watchdog.
// Ports:
//   clk, rst     core clock, synchronous active-high reset
//   hz           hazard sources in, pipeline controls out (slave modport)
//   state_o      registered FSM state (0 RUN, 1 MEM_WAIT, 2 MDU_WAIT)
//   stall_cnt_o  cycles with pc_stall_o=1, saturating
//   timeout_o    sticky: a wait lasted MAX_WAIT cycles (MAX_WAIT=0 disables)
module pipe_hazard_ctrl #(
    parameter int          CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 256
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_if.slave     hz,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             timeout_o
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] MDU_WAIT = 2'd2;

    localparam logic [31:0] WAIT_LAST = (MAX_WAIT == 0) ? 32'd0 : 32'(MAX_WAIT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]  state_q;
    logic [1:0]  state_nxt;
    logic        mdu_done_q;
    logic [31:0] wait_cnt;

    logic mem_busy, mdu_busy, load_use;
    logic pc_stall, if_id_stall, if_id_flush, hazard_flush;
    logic id_ex_stall, ex_mem_stall, ex_mem_bubble, mem_wb_bubble;
    logic in_wait_nxt;

    assign mem_busy = hz.mem_req_i & ~hz.mem_ready_i;
    // A done pulse captured during an earlier stall still counts as done.
    assign mdu_busy = hz.ex_mdu_op_i & ~(hz.mdu_done_i | mdu_done_q);
    assign load_use = hz.ex_mem_r_en_i & hz.ex_wb_en_i & (hz.ex_wb_addr_i != 5'd0) &
                      ((hz.id_rs1_ren_i & (hz.id_rs1_addr_i == hz.ex_wb_addr_i)) |
                       (hz.id_rs2_ren_i & (hz.id_rs2_addr_i == hz.ex_wb_addr_i)));

    // Priority resolution. Redirects and load-use seen under a memory/MDU stall
    // are simply ignored: EX is held, so they re-present when the stall clears.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        hazard_flush  = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        state_nxt     = RUN;
        if (mem_busy) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            state_nxt     = MEM_WAIT;
        end else if (mdu_busy) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            state_nxt     = MDU_WAIT;
        end else if (hz.ex_redirect_i) begin
            if_id_flush   = 1'b1;
            hazard_flush  = 1'b1;
        end else if (load_use) begin
            // The bubble moves the load on, so the stall lasts one cycle only.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            hazard_flush  = 1'b1;
        end
    end

    assign in_wait_nxt = (state_nxt == MEM_WAIT) || (state_nxt == MDU_WAIT);

    assign hz.pc_stall_o      = pc_stall;
    assign hz.if_id_stall_o   = if_id_stall;
    assign hz.if_id_flush_o   = if_id_flush;
    assign hz.hazard_flush_o  = hazard_flush;
    assign hz.id_ex_stall_o   = id_ex_stall;
    assign hz.ex_mem_stall_o  = ex_mem_stall;
    assign hz.ex_mem_bubble_o = ex_mem_bubble;
    assign hz.mem_wb_bubble_o = mem_wb_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            mdu_done_q  <= 1'b0;
            wait_cnt    <= 32'd0;
            stall_cnt_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state_q <= state_nxt;

            // Remember a done pulse while EX is frozen; drop it once EX moves.
            if (!id_ex_stall)
                mdu_done_q <= 1'b0;
            else if (hz.mdu_done_i)
                mdu_done_q <= 1'b1;

            if (in_wait_nxt)
                wait_cnt <= (&wait_cnt) ? wait_cnt : wait_cnt + 32'd1;
            else
                wait_cnt <= 32'd0;

            if ((MAX_WAIT != 0) && in_wait_nxt && (wait_cnt == WAIT_LAST))
                timeout_o <= 1'b1;

            if (pc_stall)
                stall_cnt_o <= sat_inc(stall_cnt_o);
        end
    end

    assign state_o = state_q;
endmodule
